// File: rtl/test1_image_generator_pkg.sv
// rtl/test1_image_generator_pkg.sv - shared codes, grid constants and scan states
//
// Purpose: object codes, grid dimensions and the scan FSM state type shared by
// the image generator and its object encoder.
package test1_image_generator_pkg;

  localparam logic [2:0] OBJ_EMPTY  = 3'd0;
  localparam logic [2:0] OBJ_BODY   = 3'd1;
  localparam logic [2:0] OBJ_HEAD   = 3'd2;
  localparam logic [2:0] OBJ_APPLE  = 3'd3;
  localparam logic [2:0] OBJ_BORDER = 3'd4;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;
  localparam int CELLS  = GRID_W * GRID_H;

  typedef enum logic [1:0] {
    ST_EVAL,
    ST_CMP,
    ST_WAIT,
    ST_ADV
  } scan_state_e;

endpackage

// File: rtl/test1_image_generator_obj_encoder.sv
// rtl/test1_image_generator_obj_encoder.sv - priority encoder from cell flags to object code
//
// Ports:
//   border, snake_head, snake_body, apple : flags for the addressed cell
//   obj_code                              : encoded object, border wins, then
//                                           head, body, apple, else empty
module test1_image_generator_obj_encoder
  import test1_image_generator_pkg::*;
(
  input  logic       border,
  input  logic       snake_head,
  input  logic       snake_body,
  input  logic       apple,
  output logic [2:0] obj_code
);

  always_comb begin
    obj_code = OBJ_EMPTY;
    if (border)          obj_code = OBJ_BORDER;
    else if (snake_head) obj_code = OBJ_HEAD;
    else if (snake_body) obj_code = OBJ_BODY;
    else if (apple)      obj_code = OBJ_APPLE;
  end

endmodule

// File: rtl/test1_image_generator.sv
// rtl/test1_image_generator.sv - frame-differencing scan controller for the snake display
//
// Walks the 16x12 grid, encodes the game flags of each cell and compares the
// code against a copy of the last drawn frame. Changed cells raise diff and
// stall the scan until the display driver answers with cmd_done.
//
// Ports:
//   clk, nrst                : clock, asynchronous active-low reset
//   snakeBody/Head, apple,
//   border                   : flags for cell (x,y), valid combinationally
//   mode_pb, GameOver        : restart request levels
//   cmd_done                 : driver finished drawing the current cell
//   x, y                     : current cell
//   obj_code                 : registered code of the current cell
//   diff                     : draw request, held until cmd_done
//   en_update                : one-cycle strobe, frame store entry written
//   enable_loop              : scanner not stalled
//   init_cycle               : first frame after reset/restart, draws all cells
//   sync_reset               : one-cycle restart pulse for downstream blocks
module test1_image_generator
  import test1_image_generator_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       snakeBody,
  input  logic       snakeHead,
  input  logic       apple,
  input  logic       border,
  input  logic       mode_pb,
  input  logic       GameOver,
  input  logic       cmd_done,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [2:0] obj_code,
  output logic       diff,
  output logic       en_update,
  output logic       enable_loop,
  output logic       init_cycle,
  output logic       sync_reset
);

  localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);

  scan_state_e state;
  logic [2:0]  enc_code;
  logic [2:0]  frame_store [CELLS];
  logic [7:0]  cell_idx;

  // Row-major index; y never exceeds 11 so {y,x} stays below 192.
  assign cell_idx = {y, x};

  test1_image_generator_obj_encoder u_obj_encoder (
    .border     (border),
    .snake_head (snakeHead),
    .snake_body (snakeBody),
    .apple      (apple),
    .obj_code   (enc_code)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_EVAL;
      x           <= '0;
      y           <= '0;
      obj_code    <= OBJ_EMPTY;
      diff        <= 1'b0;
      en_update   <= 1'b0;
      enable_loop <= 1'b1;
      init_cycle  <= 1'b1;
      sync_reset  <= 1'b0;
      for (int i = 0; i < CELLS; i++) frame_store[i] <= OBJ_EMPTY;
    end else begin
      en_update  <= 1'b0;
      sync_reset <= 1'b0;
      // Restart wins over everything, including a cmd_done on the same edge.
      if (mode_pb || GameOver) begin
        state       <= ST_EVAL;
        x           <= '0;
        y           <= '0;
        diff        <= 1'b0;
        enable_loop <= 1'b1;
        init_cycle  <= 1'b1;
        sync_reset  <= 1'b1;
        for (int i = 0; i < CELLS; i++) frame_store[i] <= OBJ_EMPTY;
      end else begin
        case (state)
          ST_EVAL: begin
            obj_code <= enc_code;
            state    <= ST_CMP;
          end
          ST_CMP: begin
            if (init_cycle || (obj_code != frame_store[cell_idx])) begin
              diff                  <= 1'b1;
              en_update             <= 1'b1;
              frame_store[cell_idx] <= obj_code;
              enable_loop           <= 1'b0;
              state                 <= ST_WAIT;
            end else begin
              state <= ST_ADV;
            end
          end
          ST_WAIT: begin
            if (cmd_done) begin
              diff        <= 1'b0;
              enable_loop <= 1'b1;
              state       <= ST_ADV;
            end
          end
          ST_ADV: begin
            if (x == X_MAX) begin
              x <= '0;
              if (y == Y_MAX) begin
                y          <= '0;
                init_cycle <= 1'b0;
              end else begin
                y <= y + 4'd1;
              end
            end else begin
              x <= x + 4'd1;
            end
            state <= ST_EVAL;
          end
          default: state <= ST_EVAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test1_image_generator.sv
// tb/tb_test1_image_generator.sv - self-checking bench for the frame-differencing scanner
module tb_test1_image_generator;

  logic       tb_clk = 1'b0;
  logic       nrst = 1'b0;
  logic       snakeBody, snakeHead, apple, border;
  logic       mode_pb = 1'b0;
  logic       GameOver = 1'b0;
  logic       cmd_done = 1'b0;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       diff, en_update, enable_loop, init_cycle, sync_reset;

  always #5 tb_clk = ~tb_clk;

  test1_image_generator dut (
    .clk         (tb_clk),
    .nrst        (nrst),
    .snakeBody   (snakeBody),
    .snakeHead   (snakeHead),
    .apple       (apple),
    .border      (border),
    .mode_pb     (mode_pb),
    .GameOver    (GameOver),
    .cmd_done    (cmd_done),
    .x           (x),
    .y           (y),
    .obj_code    (obj_code),
    .diff        (diff),
    .en_update   (en_update),
    .enable_loop (enable_loop),
    .init_cycle  (init_cycle),
    .sync_reset  (sync_reset)
  );

  // Game map model: answers the flags for the addressed cell.
  bit border_on = 1'b1;
  int head_x = 4, head_y = 4;
  int body_x = -1, body_y = -1;
  int apple_x = 7, apple_y = 4;

  always_comb begin
    border    = border_on && (x == 4'd0 || x == 4'd15 || y == 4'd0 || y == 4'd11);
    snakeHead = (int'(x) == head_x) && (int'(y) == head_y);
    snakeBody = (int'(x) == body_x) && (int'(y) == body_y);
    apple     = (int'(x) == apple_x) && (int'(y) == apple_y);
  end

  function automatic logic [2:0] code_at(input int cx, input int cy);
    if (border_on && (cx == 0 || cx == 15 || cy == 0 || cy == 11)) return 3'd4;
    if (cx == head_x && cy == head_y) return 3'd2;
    if (cx == body_x && cy == body_y) return 3'd1;
    if (cx == apple_x && cy == apple_y) return 3'd3;
    return 3'd0;
  endfunction

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int n_vec = 0, n_err = 0;
  int en_cnt = 0, en_double = 0, el_bad = 0, el_low = 0, sr_cnt = 0;
  bit en_prev = 1'b0;
  bit auto_resp = 1'b0;
  int resp_delay = 5;

  // Monitor: records every draw request at its en_update cycle.
  initial forever begin
    @(negedge tb_clk);
    if (en_update === 1'b1) begin
      obs_q.push_back({x, y, obj_code});
      en_cnt++;
      if (en_prev) en_double++;
    end
    en_prev = en_update;
    if (enable_loop !== !diff) el_bad++;
    if (enable_loop === 1'b0) el_low++;
    if (sync_reset === 1'b1) sr_cnt++;
  end

  // Display driver model: answers a held diff with a one-cycle cmd_done.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge tb_clk);
      if (cmd_done) begin
        cmd_done = 1'b0;
      end else if (auto_resp && diff === 1'b1) begin
        rcnt++;
        if (rcnt >= resp_delay) begin
          cmd_done = 1'b1;
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  task automatic wait_obs(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge tb_clk);
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_frame();
    for (int cy = 0; cy < 12; cy++)
      for (int cx = 0; cx < 16; cx++)
        exp_q.push_back({4'(cx), 4'(cy), code_at(cx, cy)});
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    auto_resp = 1'b0;
    repeat (2) @(negedge tb_clk);
    n_vec += 8;
    if (x !== 4'd0)        begin n_err++; $display("FAIL rst_x: got %0d want 0", x); end
    if (y !== 4'd0)        begin n_err++; $display("FAIL rst_y: got %0d want 0", y); end
    if (obj_code !== 3'd0) begin n_err++; $display("FAIL rst_obj: got %0d want 0", obj_code); end
    if (diff !== 1'b0)     begin n_err++; $display("FAIL rst_diff: got %b want 0", diff); end
    if (en_update !== 1'b0) begin n_err++; $display("FAIL rst_en_update: got %b want 0", en_update); end
    if (enable_loop !== 1'b1) begin n_err++; $display("FAIL rst_enable_loop: got %b want 1", enable_loop); end
    if (init_cycle !== 1'b1) begin n_err++; $display("FAIL rst_init_cycle: got %b want 1", init_cycle); end
    if (sync_reset !== 1'b0) begin n_err++; $display("FAIL rst_sync_reset: got %b want 0", sync_reset); end
    exp_q.delete();
    obs_q.delete();
    nrst = 1'b1;
    repeat (5) @(negedge tb_clk);
    n_vec += 5;
    if (x !== 4'd0) begin n_err++; $display("FAIL post_rst_x: got %0d want 0", x); end
    if (y !== 4'd0) begin n_err++; $display("FAIL post_rst_y: got %0d want 0", y); end
    if (init_cycle !== 1'b1) begin n_err++; $display("FAIL post_rst_init: got %b want 1", init_cycle); end
    if (diff !== 1'b1) begin n_err++; $display("FAIL post_rst_diff: got %b want 1", diff); end
    if (enable_loop !== 1'b0) begin n_err++; $display("FAIL post_rst_enable_loop: got %b want 0", enable_loop); end
  endtask

  task automatic test_init_frame();
    logic [10:0] e, o;
    bit ok;
    push_frame();
    auto_resp = 1'b1;
    wait_obs(192, 4000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL init_count: got %0d requests want 192", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL init_req: none, want x=%0d y=%0d code=%0d", e[10:7], e[6:3], e[2:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL init_req: got x=%0d y=%0d code=%0d want x=%0d y=%0d code=%0d",
                   o[10:7], o[6:3], o[2:0], e[10:7], e[6:3], e[2:0]);
        end
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (init_cycle === 1'b0) begin ok = 1'b1; break; end
      @(negedge tb_clk);
    end
    n_vec++;
    if (init_cycle !== 1'b0) begin n_err++; $display("FAIL init_clear: got %b want 0", init_cycle); end
    n_vec++;
    if (en_double !== 0) begin n_err++; $display("FAIL init_en_width: got %0d long strobes want 0", en_double); end
  endtask

  task automatic test_static();
    int el0;
    el0 = el_low;
    obs_q.delete();
    repeat (576) @(negedge tb_clk);
    n_vec += 3;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL static_requests: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    if (el_low - el0 !== 0) begin n_err++; $display("FAIL static_enable_loop: got %0d stalled cycles want 0", el_low - el0); end
    if (el_bad !== 0) begin n_err++; $display("FAIL enable_loop_vs_diff: got %0d bad cycles want 0", el_bad); end
  endtask

  task automatic test_move();
    logic [10:0] e, o;
    bit ok;
    int en0;
    en0 = en_cnt;
    obs_q.delete();
    head_x = 5; head_y = 4;
    body_x = 4; body_y = 4;
    exp_q.push_back({4'd4, 4'd4, 3'd1});
    exp_q.push_back({4'd5, 4'd4, 3'd2});
    wait_obs(2, 700, ok);
    repeat (600) @(negedge tb_clk);
    n_vec++;
    if (en_cnt - en0 !== 2) begin n_err++; $display("FAIL move_count: got %0d requests want 2", en_cnt - en0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL move_req: none, want x=%0d y=%0d code=%0d", e[10:7], e[6:3], e[2:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL move_req: got x=%0d y=%0d code=%0d want x=%0d y=%0d code=%0d",
                   o[10:7], o[6:3], o[2:0], e[10:7], e[6:3], e[2:0]);
        end
      end
    end
    n_vec++;
    if (en_double !== 0) begin n_err++; $display("FAIL move_en_width: got %0d long strobes want 0", en_double); end
  endtask

  task automatic test_stall();
    logic [10:0] e, o;
    logic [3:0] sx, sy;
    logic [2:0] sc;
    bit ok;
    int bad;
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge tb_clk);
      if (x === 4'd0 && y === 4'd0) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL stall_sync: got x=%0d y=%0d want 0,0", x, y); end
    auto_resp = 1'b0;
    obs_q.delete();
    apple_x = 10; apple_y = 8;
    exp_q.push_back({4'd7, 4'd4, 3'd0});
    exp_q.push_back({4'd10, 4'd8, 3'd3});
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge tb_clk);
      if (diff === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL stall_req: got diff=%b want 1", diff); end
    sx = x; sy = y; sc = obj_code;
    bad = 0;
    repeat (20) begin
      @(negedge tb_clk);
      if (x !== sx || y !== sy || obj_code !== sc || diff !== 1'b1 || enable_loop !== 1'b0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL stall_frozen: got %0d moving cycles want 0", bad); end
    auto_resp = 1'b1;
    wait_obs(2, 700, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL stall_req: none, want x=%0d y=%0d code=%0d", e[10:7], e[6:3], e[2:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL stall_req: got x=%0d y=%0d code=%0d want x=%0d y=%0d code=%0d",
                   o[10:7], o[6:3], o[2:0], e[10:7], e[6:3], e[2:0]);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [10:0] e, o;
    bit ok;
    int sr0;
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge tb_clk);
      if (y === 4'd5) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL restart_sync: got y=%0d want 5", y); end
    sr0 = sr_cnt;
    GameOver = 1'b1;
    @(negedge tb_clk);
    GameOver = 1'b0;
    obs_q.delete();
    n_vec += 5;
    if (sync_reset !== 1'b1) begin n_err++; $display("FAIL restart_pulse: got %b want 1", sync_reset); end
    if (x !== 4'd0) begin n_err++; $display("FAIL restart_x: got %0d want 0", x); end
    if (y !== 4'd0) begin n_err++; $display("FAIL restart_y: got %0d want 0", y); end
    if (init_cycle !== 1'b1) begin n_err++; $display("FAIL restart_init: got %b want 1", init_cycle); end
    if (diff !== 1'b0) begin n_err++; $display("FAIL restart_diff: got %b want 0", diff); end
    @(negedge tb_clk);
    n_vec++;
    if (sr_cnt - sr0 !== 1) begin n_err++; $display("FAIL restart_pulse_len: got %0d cycles want 1", sr_cnt - sr0); end
    push_frame();
    wait_obs(192, 4000, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL redraw_req: none, want x=%0d y=%0d code=%0d", e[10:7], e[6:3], e[2:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL redraw_req: got x=%0d y=%0d code=%0d want x=%0d y=%0d code=%0d",
                   o[10:7], o[6:3], o[2:0], e[10:7], e[6:3], e[2:0]);
        end
      end
    end
    for (int i = 0; i < 100; i++) begin
      if (init_cycle === 1'b0) break;
      @(negedge tb_clk);
    end
    n_vec++;
    if (init_cycle !== 1'b0) begin n_err++; $display("FAIL redraw_init_clear: got %b want 0", init_cycle); end
  endtask

  initial begin
    test_reset();
    test_init_frame();
    test_static();
    test_move();
    test_stall();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test1_image_generator.md
# test1_image_generator

Frame-differencing scan controller for the snake-game display path. It walks a 16×12 cell grid and encodes the object flags the game logic returns for the addressed cell into a 3-bit object code. It compares that code against a stored copy of the last drawn frame and, for each changed cell, raises a draw request to the display command driver, stalling until the driver reports completion. It sits between the game-state logic, which supplies the flags combinationally from x/y, and the LCD command/pixel writer, which consumes x, y, obj_code and diff and returns cmd_done.

## Interface
- No parameters. Grid is fixed at 16×12.
- clk  in  1  system clock; all logic is on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- snakeBody  in  1  addressed cell holds a snake body segment.
- snakeHead  in  1  addressed cell holds the snake head.
- apple  in  1  addressed cell holds the apple.
- border  in  1  addressed cell is a wall.
- mode_pb  in  1  mode push-button, already debounced; a level high forces a restart.
- GameOver  in  1  game-over level; high forces a restart.
- cmd_done  in  1  display driver has finished drawing the current cell; sampled on the rising edge.
- x  out  4  current column, 0..15.
- y  out  4  current row, 0..11.
- obj_code  out  3  registered code for cell (x,y).
- diff  out  1  draw request for the current cell.
- en_update  out  1  one-cycle strobe; the stored frame entry for (x,y) is written on this cycle.
- enable_loop  out  1  scanner is free-running, i.e. not stalled on cmd_done.
- init_cycle  out  1  first full frame after reset or restart; forces every cell to be drawn.
- sync_reset  out  1  one-cycle restart pulse to downstream blocks.

## Operation
- Object codes, in priority order: border → 4, snakeHead → 2, snakeBody → 1, apple → 3, none → 0.
- Frame store holds 16×12 entries of 3 bits. Reset and restart clear every entry to 0.
- The FSM has four states: EVAL, CMP, WAIT, ADV.
  - EVAL: register obj_code from the input flags for the current (x,y). Go to CMP.
  - CMP: if init_cycle=1 or obj_code ≠ store[x][y], set diff=1, pulse en_update (the store takes obj_code), and go to WAIT. Otherwise go to ADV.
  - WAIT: hold diff=1 and keep x, y, obj_code stable. When cmd_done is sampled high, drop diff and go to ADV.
  - ADV: step x. At x=15, x wraps to 0 and y increments. At x=15 and y=11, the position wraps to (0,0) and init_cycle is cleared. Go to EVAL.
- enable_loop = 1 in EVAL, CMP and ADV; 0 in WAIT.
- Restart: mode_pb or GameOver sampled high from any state triggers the following on the next edge:
  - x=y=0 and the state returns to EVAL;
  - the frame store is cleared;
  - init_cycle=1 and diff=0;
  - sync_reset=1 for one cycle.
  Restart takes priority over cmd_done. If the request level stays high, the block keeps restarting.
- cmd_done sampled outside WAIT is ignored.

## Timing
- Reset values: x=0, y=0, obj_code=0, diff=0, en_update=0, enable_loop=1, init_cycle=1, sync_reset=0, state=EVAL, store all 0.
- The flag inputs must be valid combinationally from x/y within one cycle. They are sampled in EVAL, one cycle after x/y change.
- For a changed cell, diff rises two edges after the coordinate update (EVAL then CMP). en_update is coincident with the first diff cycle.
- After cmd_done is sampled, the next cell's coordinates appear one edge later (ADV).
- An unchanged cell costs 3 cycles. A full idle frame costs 576 cycles.
- The init frame issues 192 draw requests.
- cmd_done may be a pulse of one cycle or shorter, provided it spans a rising edge.

## Structure
- Shared package holds:
  - obj_code localparams: OBJ_EMPTY=0, OBJ_BODY=1, OBJ_HEAD=2, OBJ_APPLE=3, OBJ_BORDER=4;
  - grid constants: GRID_W=16, GRID_H=12;
  - the FSM state enum.
- One sub-module, obj_encoder: a combinational priority encoder from the four flags to obj_code. The FSM, counters and frame store stay in the top module.

## Test plan
- Reset: hold nrst low for 2 cycles, release, wait 5 cycles with no cmd_done. Required: x=0, y=0, init_cycle=1, diff=1, enable_loop=0.
- Init frame: answer every diff with a cmd_done pulse 5 cycles later. Required: 192 requests in raster order (0,0),(1,0)…(15,11), then init_cycle=0.
- Static map (border, head at (4,4), apple at (7,4)): on the second frame, diff never asserts and enable_loop stays 1.
- Head moves from (4,4) to (5,4) with body at (4,4): the next frame issues exactly two requests, (4,4) with code 1 and (5,4) with code 2, each with a one-cycle en_update.
- Stall: withhold cmd_done for 20 cycles while diff=1. Required: x, y and obj_code are frozen and diff is held high.
- Restart: pulse GameOver mid-frame. Required: sync_reset=1 for one cycle, x=y=0, init_cycle=1, and a full frame is redrawn.
